pipe_ifd_stage: RTL and testbench

- Parametrised IF/ID pipeline register that sits between instruction fetch and the decode/register-read stage.
- Splits each fetched instruction word into opcode, destination, source A, source B, address and extended-immediate fields, and carries the fetch PC with it.
- Adds what the fixed 32-bit latch lacks:
  - valid/ready handshake with a two-entry skid buffer, so upstream can stall at full throughput;
  - synchronous flush for branch redirects;
  - selectable sign or zero extension of the immediate;
  - asynchronous active-low reset.

---
 rtl/pipe_ifd_stage.sv | 121 ++++++++++++
 tb/tb_pipe_ifd_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ifd_stage.sv
// IF/ID pipeline register with a two-entry skid buffer, field decode on capture,
// selectable immediate extension and synchronous flush for branch redirects.
module pipe_ifd_stage #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               imm_sext,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode_out,
  output logic [REG_W-1:0]   dir_write_out,
  output logic [REG_W-1:0]   dir_reg_a_out,
  output logic [REG_W-1:0]   dir_reg_b_out,
  output logic [IMM_W-1:0]   direccion_out,
  output logic [INSTR_W-1:0] inm_out,
  output logic [PC_W-1:0]    pc_out
);

  localparam int unsigned RD_HI   = INSTR_W - OPC_W - 1;
  localparam int unsigned RA_HI   = RD_HI - REG_W;
  localparam int unsigned RB_HI   = RA_HI - REG_W;
  localparam int unsigned ENTRY_W = OPC_W + 3 * REG_W + IMM_W + INSTR_W + PC_W;

  logic [OPC_W-1:0]   in_opc_c;
  logic [REG_W-1:0]   in_rd_c;
  logic [REG_W-1:0]   in_ra_c;
  logic [REG_W-1:0]   in_rb_c;
  logic [IMM_W-1:0]   in_imm_c;
  logic [INSTR_W-1:0] in_ext_c;
  logic [ENTRY_W-1:0] in_entry_c;

  logic               acc_c;
  logic               drain_c;

  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ENTRY_W-1:0] main_entry_q, main_entry_d;
  logic [ENTRY_W-1:0] skid_entry_q, skid_entry_d;

  // Field extraction from the incoming word
  assign in_opc_c = in_instr[INSTR_W-1 -: OPC_W];
  assign in_rd_c  = in_instr[RD_HI -: REG_W];
  assign in_ra_c  = in_instr[RA_HI -: REG_W];
  assign in_rb_c  = in_instr[RB_HI -: REG_W];
  assign in_imm_c = in_instr[IMM_W-1:0];

  generate
    if (IMM_W < INSTR_W) begin : g_ext
      assign in_ext_c = {{(INSTR_W-IMM_W){imm_sext & in_imm_c[IMM_W-1]}}, in_imm_c};
    end else begin : g_noext
      logic unused_sext;
      assign unused_sext = imm_sext;
      assign in_ext_c    = in_imm_c;
    end
  endgenerate

  assign in_entry_c = {in_opc_c, in_rd_c, in_ra_c, in_rb_c, in_imm_c, in_ext_c, in_pc};

  // in_ready comes straight from state so there is no path from out_ready
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign acc_c     = in_valid & ~skid_valid_q;
  assign drain_c   = main_valid_q & out_ready;

  // Next-state: skid is always older than the input, so it refills main first
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_entry_d = main_entry_q;
    skid_entry_d = skid_entry_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain_c) begin
      if (skid_valid_q) begin
        main_entry_d = skid_entry_q;
        main_valid_d = 1'b1;
        skid_valid_d = acc_c;
        if (acc_c) begin
          skid_entry_d = in_entry_c;
        end
      end else if (acc_c) begin
        main_entry_d = in_entry_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc_c) begin
      skid_entry_d = in_entry_c;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_entry_q <= '0;
      skid_entry_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_entry_q <= main_entry_d;
      skid_entry_q <= skid_entry_d;
    end
  end

  assign {opcode_out, dir_write_out, dir_reg_a_out, dir_reg_b_out,
          direccion_out, inm_out, pc_out} = main_entry_q;

endmodule

// File: tb/tb_pipe_ifd_stage.sv
// Directed self-checking bench for pipe_ifd_stage: default and narrow configurations.
module tb_pipe_ifd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        imm_sext;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  opcode_out;
  logic [4:0]  dir_write_out;
  logic [4:0]  dir_reg_a_out;
  logic [4:0]  dir_reg_b_out;
  logic [15:0] direccion_out;
  logic [31:0] inm_out;
  logic [31:0] pc_out;

  logic        s_in_ready;
  logic [23:0] s_in_instr;
  logic        s_out_valid;
  logic [3:0]  s_opcode_out;
  logic [3:0]  s_dir_write_out;
  logic [3:0]  s_dir_reg_a_out;
  logic [3:0]  s_dir_reg_b_out;
  logic [11:0] s_direccion_out;
  logic [23:0] s_inm_out;
  logic [31:0] s_pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ifd_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .imm_sext(imm_sext), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
    .dir_write_out(dir_write_out), .dir_reg_a_out(dir_reg_a_out),
    .dir_reg_b_out(dir_reg_b_out), .direccion_out(direccion_out),
    .inm_out(inm_out), .pc_out(pc_out)
  );

  pipe_ifd_stage #(.INSTR_W(24), .OPC_W(4), .REG_W(4), .IMM_W(12), .PC_W(32)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .in_pc(in_pc), .imm_sext(imm_sext), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .opcode_out(s_opcode_out),
    .dir_write_out(s_dir_write_out), .dir_reg_a_out(s_dir_reg_a_out),
    .dir_reg_b_out(s_dir_reg_b_out), .direccion_out(s_direccion_out),
    .inm_out(s_inm_out), .pc_out(s_pc_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = 32'h1000_0000 | pc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; imm_sext = 1'b0;
    flush = 1'b0; out_ready = 1'b0; s_in_instr = '0;
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_pc_out", 64'(pc_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Decode in both configurations
    in_valid = 1'b1; in_instr = 32'h5A6A_8FFF; in_pc = 32'h10; imm_sext = 1'b1;
    s_in_instr = 24'hA12F80; out_ready = 1'b1;
    tick();
    check_eq("dec_valid", 64'(out_valid), 64'd1);
    check_eq("dec_opcode", 64'(opcode_out), 64'h0B);
    check_eq("dec_rd", 64'(dir_write_out), 64'd9);
    check_eq("dec_ra", 64'(dir_reg_a_out), 64'd21);
    check_eq("dec_rb", 64'(dir_reg_b_out), 64'd8);
    check_eq("dec_dir", 64'(direccion_out), 64'h8FFF);
    check_eq("dec_inm_sext", 64'(inm_out), 64'hFFFF_8FFF);
    check_eq("dec_pc", 64'(pc_out), 64'h10);
    check_eq("s_opcode", 64'(s_opcode_out), 64'hA);
    check_eq("s_rd", 64'(s_dir_write_out), 64'h1);
    check_eq("s_ra", 64'(s_dir_reg_a_out), 64'h2);
    check_eq("s_rb", 64'(s_dir_reg_b_out), 64'hF);
    check_eq("s_dir", 64'(s_direccion_out), 64'hF80);
    check_eq("s_inm", 64'(s_inm_out), 64'hFF_FF80);
    imm_sext = 1'b0; in_pc = 32'h14;
    tick();
    check_eq("dec_inm_zext", 64'(inm_out), 64'h0000_8FFF);
    check_eq("dec_pc2", 64'(pc_out), 64'h14);
    in_valid = 1'b0;
    tick();
    check_eq("drain_empty", 64'(out_valid), 64'd0);
    check_eq("hold_after_drain", 64'(pc_out), 64'h14);

    // Back-pressure: fill main and skid, then release
    out_ready = 1'b0;
    push(32'h100);
    tick();
    check_eq("bp_main_pc", 64'(pc_out), 64'h100);
    check_eq("bp_ready1", 64'(in_ready), 64'd1);
    push(32'h104);
    tick();
    check_eq("bp_hold_pc", 64'(pc_out), 64'h100);
    check_eq("bp_ready0", 64'(in_ready), 64'd0);
    push(32'h108);
    tick();
    check_eq("bp_stall_pc", 64'(pc_out), 64'h100);
    check_eq("bp_stall_inm", 64'(inm_out), 64'h0000_0100);
    check_eq("bp_stall_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check_eq("bp_rel_pc1", 64'(pc_out), 64'h104);
    check_eq("bp_rel_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("bp_rel_pc2", 64'(pc_out), 64'h108);
    check_eq("bp_rel_valid2", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    check_eq("bp_no_dup", 64'(out_valid), 64'd0);

    // Full throughput: one instruction per cycle, never stalling
    for (int i = 0; i < 16; i++) begin
      push(32'h400 + 32'(4 * i));
      tick();
      check_eq("ft_pc", 64'(pc_out), 64'(32'h400 + 32'(4 * i)));
      check_eq("ft_ready", 64'(in_ready & out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick();

    // Flush with both entries full and an offered instruction
    out_ready = 1'b0;
    push(32'h500);
    tick();
    push(32'h504);
    tick();
    check_eq("fl_full", 64'(in_ready), 64'd0);
    push(32'h200); flush = 1'b1;
    tick();
    check_eq("fl_valid", 64'(out_valid), 64'd0);
    check_eq("fl_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("fl_beats_acc", 64'(out_valid), 64'd0);
    flush = 1'b0; push(32'h300); out_ready = 1'b1;
    tick();
    check_eq("fl_next_valid", 64'(out_valid), 64'd1);
    check_eq("fl_next_pc", 64'(pc_out), 64'h300);
    in_valid = 1'b0;
    tick();
    check_eq("fl_no_200", 64'(out_valid), 64'd0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    push(32'h600);
    tick();
    push(32'h604);
    tick();
    check_eq("rm_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rm_valid", 64'(out_valid), 64'd0);
    check_eq("rm_ready", 64'(in_ready), 64'd1);
    check_eq("rm_pc", 64'(pc_out), 64'd0);
    check_eq("rm_inm", 64'(inm_out), 64'd0);
    check_eq("rm_opcode", 64'(opcode_out), 64'd0);
    check_eq("rm_s_inm", 64'(s_inm_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("rm_after", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
